// File: rtl/id_ex_stage_if.sv
// Bundles the ID-side inputs, the write-back inputs used for forwarding,
// the pipeline control signals and the registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // decoded instruction in ID
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_a, id_b;
  logic [15:0]       id_imm;
  logic              id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
  logic [3:0]        id_alu_op;
  logic              id_valid;
  // write-back info from later stages, used for forwarding
  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_rd;
  logic [DATA_W-1:0] exm_result;
  logic              mwb_reg_write;
  logic [REG_AW-1:0] mwb_rd;
  logic [DATA_W-1:0] mwb_data;
  // pipeline control
  logic              hold, flush, stall;
  // registered EX-side outputs
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]        ex_alu_op;

  modport master (
    output id_rs, id_rt, id_rd, id_a, id_b, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_alu_op, id_valid,
           exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_data, hold, flush,
    input  stall, ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_a, id_b, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_alu_op, id_valid,
           exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_data, hold, flush,
    output stall, ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding at ID, load-use
// detection and flush/hold handling. Priority per edge:
// reset > flush > hold > load-use bubble > normal load.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [3:0]        alu_op;
  } ex_t;

  ex_t               ex_q, ex_d;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              lu;

  // Operand forwarding: EX/MEM wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_a = bus.id_a;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == bus.id_rs)
      fwd_a = bus.exm_result;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == bus.id_rs)
      fwd_a = bus.mwb_data;

    fwd_b = bus.id_b;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == bus.id_rt)
      fwd_b = bus.exm_result;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == bus.id_rt)
      fwd_b = bus.mwb_data;
  end

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded yet; it costs one bubble and resolves via MEM/WB next cycle.
  assign lu = ex_q.valid && ex_q.mem_read && ex_q.dest != '0 &&
              (ex_q.dest == bus.id_rs || ex_q.dest == bus.id_rt) && bus.id_valid;

  assign bus.stall = (lu || bus.hold) && !reset;

  // Next-state selection; datapath fields are left as-is on flush/bubble.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush || (!bus.hold && lu)) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.alu_src   = 1'b0;
      ex_d.alu_op    = '0;
    end else if (!bus.hold) begin
      ex_d.valid     = bus.id_valid;
      ex_d.a         = fwd_a;
      ex_d.b         = fwd_b;
      ex_d.imm       = {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};
      ex_d.rs        = bus.id_rs;
      ex_d.rt        = bus.id_rt;
      ex_d.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      ex_d.reg_write = bus.id_reg_write & bus.id_valid;
      ex_d.mem_read  = bus.id_mem_read  & bus.id_valid;
      ex_d.mem_write = bus.id_mem_write & bus.id_valid;
      ex_d.alu_src   = bus.id_alu_src   & bus.id_valid;
      ex_d.alu_op    = bus.id_valid ? bus.id_alu_op : 4'd0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_a         = ex_q.a;
  assign bus.ex_b         = ex_q.b;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_alu_src   = ex_q.alu_src;
  assign bus.ex_alu_op    = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each task drives one scenario and checks
// its outputs against hand-computed values.
module tb_id_ex_stage;
  logic clk, reset;
  int total, bad;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_a = '0; bus.id_b = '0; bus.id_imm = '0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_alu_src = 0; bus.id_reg_dst = 0; bus.id_alu_op = '0; bus.id_valid = 0;
    bus.exm_reg_write = 0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.mwb_reg_write = 0; bus.mwb_rd = '0; bus.mwb_data = '0;
    bus.hold = 0; bus.flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; bus.hold = 1; #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", bus.ex_valid); end
    total++; if (bus.ex_a !== 32'h0) begin bad++; $display("FAIL rst_a got=%h exp=0", bus.ex_a); end
    total++; if (bus.ex_dest !== 5'd0) begin bad++; $display("FAIL rst_dest got=%0d exp=0", bus.ex_dest); end
    total++; if (bus.ex_imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", bus.ex_imm); end
    reset = 0; bus.hold = 0;
  endtask

  task automatic test_basic();
    clear_inputs();
    bus.id_rs = 2; bus.id_a = 90; bus.id_rt = 1; bus.id_b = 10;
    bus.id_reg_dst = 1; bus.id_rd = 3; bus.id_valid = 1; bus.id_reg_write = 1; bus.id_alu_op = 4'd6;
    tick();
    total++; if (bus.ex_a !== 32'd90) begin bad++; $display("FAIL basic_a got=%0d exp=90", bus.ex_a); end
    total++; if (bus.ex_b !== 32'd10) begin bad++; $display("FAIL basic_b got=%0d exp=10", bus.ex_b); end
    total++; if (bus.ex_dest !== 5'd3) begin bad++; $display("FAIL basic_dest got=%0d exp=3", bus.ex_dest); end
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", bus.ex_valid); end
    total++; if (bus.ex_reg_write !== 1'b1) begin bad++; $display("FAIL basic_rw got=%0b exp=1", bus.ex_reg_write); end
    total++; if (bus.ex_alu_op !== 4'd6) begin bad++; $display("FAIL basic_op got=%0d exp=6", bus.ex_alu_op); end
    total++; if (bus.ex_rs !== 5'd2 || bus.ex_rt !== 5'd1) begin bad++; $display("FAIL basic_rsrt got=%0d/%0d exp=2/1", bus.ex_rs, bus.ex_rt); end
  endtask

  task automatic test_forward();
    clear_inputs();
    bus.id_rs = 2; bus.id_a = 32'h11; bus.id_valid = 1;
    bus.exm_reg_write = 1; bus.exm_rd = 2; bus.exm_result = 32'h55;
    bus.mwb_reg_write = 1; bus.mwb_rd = 2; bus.mwb_data = 32'h66;
    tick();
    total++; if (bus.ex_a !== 32'h55) begin bad++; $display("FAIL fwd_exm_prio got=%h exp=55", bus.ex_a); end
    bus.exm_rd = 0;
    tick();
    total++; if (bus.ex_a !== 32'h66) begin bad++; $display("FAIL fwd_mwb got=%h exp=66", bus.ex_a); end
    // r0 never forwarded, even when both stages claim to write it
    bus.id_rs = 0; bus.id_rt = 0; bus.id_a = 32'h77; bus.id_b = 32'h88; bus.mwb_rd = 0;
    tick();
    total++; if (bus.ex_a !== 32'h77) begin bad++; $display("FAIL fwd_r0_a got=%h exp=77", bus.ex_a); end
    total++; if (bus.ex_b !== 32'h88) begin bad++; $display("FAIL fwd_r0_b got=%h exp=88", bus.ex_b); end
    // B operand via MEM/WB; write-enable low must block forwarding on A
    bus.id_rs = 4; bus.id_rt = 9; bus.id_a = 32'hA0; bus.id_b = 32'hB0;
    bus.exm_reg_write = 0; bus.exm_rd = 4; bus.exm_result = 32'hDEAD;
    bus.mwb_rd = 9; bus.mwb_data = 32'h1234;
    tick();
    total++; if (bus.ex_a !== 32'hA0) begin bad++; $display("FAIL fwd_nowe_a got=%h exp=a0", bus.ex_a); end
    total++; if (bus.ex_b !== 32'h1234) begin bad++; $display("FAIL fwd_mwb_b got=%h exp=1234", bus.ex_b); end
  endtask

  task automatic test_imm();
    clear_inputs();
    bus.id_valid = 1; bus.id_imm = 16'h8001;
    tick();
    total++; if (bus.ex_imm !== 32'hFFFF8001) begin bad++; $display("FAIL imm_neg got=%h exp=ffff8001", bus.ex_imm); end
    bus.id_imm = 16'h7FFF;
    tick();
    total++; if (bus.ex_imm !== 32'h00007FFF) begin bad++; $display("FAIL imm_pos got=%h exp=00007fff", bus.ex_imm); end
  endtask

  task automatic test_invalid();
    clear_inputs();
    bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_write = 1;
    bus.id_alu_src = 1; bus.id_alu_op = 4'hF;
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL inv_valid got=%0b exp=0", bus.ex_valid); end
    total++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src} !== 4'b0)
      begin bad++; $display("FAIL inv_ctrl got=%b exp=0000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src}); end
    total++; if (bus.ex_alu_op !== 4'd0) begin bad++; $display("FAIL inv_op got=%0d exp=0", bus.ex_alu_op); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    // lw r5 <- mem: dest taken from rt since reg_dst=0
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rt = 5; bus.id_rd = 9;
    tick();
    total++; if (bus.ex_dest !== 5'd5) begin bad++; $display("FAIL lu_dest got=%0d exp=5", bus.ex_dest); end
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 5; bus.id_rt = 1; bus.id_a = 7; bus.id_b = 3;
    bus.id_reg_dst = 1; bus.id_rd = 6; bus.id_reg_write = 1;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%0b exp=0", bus.ex_valid); end
    total++; if (bus.ex_mem_read !== 1'b0) begin bad++; $display("FAIL lu_bubble_mr got=%0b exp=0", bus.ex_mem_read); end
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL lu_bubble_rw got=%0b exp=0", bus.ex_reg_write); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%0b exp=0", bus.stall); end
    // the load has reached WB; the retried instruction picks it up there
    bus.mwb_reg_write = 1; bus.mwb_rd = 5; bus.mwb_data = 32'h1234;
    tick();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_issue_valid got=%0b exp=1", bus.ex_valid); end
    total++; if (bus.ex_a !== 32'h1234) begin bad++; $display("FAIL lu_issue_a got=%h exp=1234", bus.ex_a); end
    total++; if (bus.ex_dest !== 5'd6) begin bad++; $display("FAIL lu_issue_dest got=%0d exp=6", bus.ex_dest); end
  endtask

  task automatic test_hold();
    clear_inputs();
    bus.id_valid = 1; bus.id_a = 32'hAAAA; bus.id_b = 32'hBBBB; bus.id_reg_dst = 1; bus.id_rd = 7;
    bus.id_reg_write = 1; bus.id_alu_op = 4'd3;
    tick();
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_a = 32'(i + 1); bus.id_rd = 5'(i + 10); bus.id_alu_op = 4'(i + 8); bus.id_valid = i[0];
      #1;
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%0b exp=1", i, bus.stall); end
      tick();
      total++; if (bus.ex_a !== 32'hAAAA || bus.ex_dest !== 5'd7 || bus.ex_valid !== 1'b1 || bus.ex_alu_op !== 4'd3)
        begin bad++; $display("FAIL hold_keep[%0d] got a=%h d=%0d v=%0b op=%0d exp a=aaaa d=7 v=1 op=3", i, bus.ex_a, bus.ex_dest, bus.ex_valid, bus.ex_alu_op); end
    end
    bus.flush = 1;
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", bus.ex_valid); end
    total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'd0)
      begin bad++; $display("FAIL flush_ctrl got rw=%0b op=%0d exp 0/0", bus.ex_reg_write, bus.ex_alu_op); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.id_valid = 1; bus.id_a = 32'h11; bus.id_reg_dst = 1; bus.id_rd = 1;
    tick();
    total++; if (bus.ex_a !== 32'h11) begin bad++; $display("FAIL b2b_first got=%h exp=11", bus.ex_a); end
    bus.id_a = 32'h22; bus.id_rt = 1; bus.id_b = 32'h5;
    bus.exm_reg_write = 1; bus.exm_rd = 1; bus.exm_result = 32'h99;
    tick();
    total++; if (bus.ex_a !== 32'h22) begin bad++; $display("FAIL b2b_second_a got=%h exp=22", bus.ex_a); end
    total++; if (bus.ex_b !== 32'h99) begin bad++; $display("FAIL b2b_second_b got=%h exp=99", bus.ex_b); end
  endtask

  task automatic test_reset_mid_hazard();
    clear_inputs();
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rt = 5;
    bus.id_a = 32'h3C; bus.id_imm = 16'hFFFF;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 5;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rsth_lu_active got=%0b exp=1", bus.stall); end
    bus.hold = 1; reset = 1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rsth_stall got=%0b exp=0", bus.stall); end
    tick();
    total++; if ({bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write} !== 3'b0 || bus.ex_dest !== 5'd0 || bus.ex_a !== 32'h0 || bus.ex_imm !== 32'h0)
      begin bad++; $display("FAIL rsth_clear got v=%0b mr=%0b d=%0d a=%h imm=%h exp all 0", bus.ex_valid, bus.ex_mem_read, bus.ex_dest, bus.ex_a, bus.ex_imm); end
    reset = 0; clear_inputs();
  endtask

  initial begin
    total = 0; bad = 0;
    clear_inputs();
    reset = 1;
    tick();
    test_reset();
    test_basic();
    test_forward();
    test_imm();
    test_invalid();
    test_load_use();
    test_hold();
    test_back_to_back();
    test_reset_mid_hazard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
